// File: rtl/pq_pkg.sv
// Shared types and constants for the priority-queue event scheduler and its PQ device.
package pq_pkg;

    localparam int KW          = 8;
    localparam int VW          = 8;
    localparam int PQ_CAPACITY = 4;

    // All-ones key marks an empty or invalid timestamp; now saturates one below it.
    localparam logic [KW-1:0] KEYINF  = '1;
    localparam logic [KW-1:0] NOW_MAX = KEYINF - 1'b1;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] value;
    } kv_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP,
        S_SETTLE,
        S_FLUSH
    } sched_state_t;

endpackage

// File: rtl/pq_int.sv
// Push/pop interface between a priority-queue client and a priority-queue device.
interface pq_int;
    import pq_pkg::*;

    logic push;
    logic pop;
    kv_t  idata;
    kv_t  odata;
    logic full;
    logic empty;

    modport pq_client (output push, output pop, output idata,
                       input odata, input full, input empty);
    modport pq_dev    (input push, input pop, input idata,
                       output odata, output full, output empty);
endinterface

// File: rtl/pq_tick_ctr.sv
// Time base: a TICK_DIV prescaler feeding a saturating "now" counter.
module pq_tick_ctr
    import pq_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_en,
    output logic [KW-1:0] now
);
    localparam int            DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [KW-1:0] now_q;
    logic [KW-1:0] now_d;
    logic          tick;

    // Prescaler wraps every TICK_DIV enabled cycles; now stops one below KEYINF.
    always_comb begin
        div_d = div_q;
        now_d = now_q;
        tick  = 1'b0;
        if (tick_en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                tick  = 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        if (tick && (now_q != NOW_MAX)) begin
            now_d = now_q + 1'b1;
        end
    end

    // Prescaler and time registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            now_q <= '0;
        end else begin
            div_q <= div_d;
            now_q <= now_d;
        end
    end

    assign now = now_q;

endmodule

// File: rtl/sr_pq.sv
// Sorted shift-register priority queue: smallest key at the head, equal keys kept in
// arrival order. Head, empty and full are registered and reflect an op the cycle after it.
module sr_pq
    import pq_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    pq_int.pq_dev  pd
);
    localparam int CW = $clog2(PQ_CAPACITY + 1);

    kv_t                    arr_q [PQ_CAPACITY];
    kv_t                    arr_d [PQ_CAPACITY];
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [PQ_CAPACITY-1:0] keep;
    logic                   do_push;
    logic                   do_pop;

    // Push wins if a client ever drives both; ops on a full/empty queue are ignored.
    assign do_push = pd.push && (cnt_q != CW'(PQ_CAPACITY));
    assign do_pop  = pd.pop && (cnt_q != '0) && !do_push;

    // Slots that stay in place on insertion: occupied and not greater than the new key.
    always_comb begin
        keep = '0;
        for (int i = 0; i < PQ_CAPACITY; i++) begin
            keep[i] = (CW'(i) < cnt_q) && (arr_q[i].key <= pd.idata.key);
        end
    end

    // Next array contents: sorted insert on push, shift toward the head on pop.
    always_comb begin
        arr_d = arr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            arr_d[0] = keep[0] ? arr_q[0] : pd.idata;
            for (int i = 1; i < PQ_CAPACITY; i++) begin
                if (keep[i]) begin
                    arr_d[i] = arr_q[i];
                end else if (keep[i-1]) begin
                    arr_d[i] = pd.idata;
                end else begin
                    arr_d[i] = arr_q[i-1];
                end
            end
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop) begin
            for (int i = 0; i < PQ_CAPACITY - 1; i++) begin
                arr_d[i] = arr_q[i+1];
            end
            arr_d[PQ_CAPACITY-1] = '0;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Queue storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PQ_CAPACITY; i++) begin
                arr_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            arr_q <= arr_d;
            cnt_q <= cnt_d;
        end
    end

    assign pd.odata = arr_q[0];
    assign pd.empty = (cnt_q == '0);
    assign pd.full  = (cnt_q == CW'(PQ_CAPACITY));

endmodule

// File: rtl/pq_event_sched.sv
// Event scheduler: pushes timestamped events into the attached PQ, pops the head once it
// is due and presents it on a one-entry output slot. Every PQ op is followed by a settle
// cycle so the device's registered head/empty/full are current when next examined.
module pq_event_sched
    import pq_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [KW-1:0] in_key,
    input  logic [VW-1:0] in_value,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW-1:0] out_key,
    output logic [VW-1:0] out_value,
    input  logic          tick_en,
    output logic [KW-1:0] now,
    input  logic          flush,
    output logic          busy,
    output logic          err_key,
    pq_int.pq_client      pi
);
    sched_state_t  state_q, state_d;
    logic          rr_q, rr_d;
    logic          flush_pend_q, flush_pend_d;
    logic          flush_ph_q, flush_ph_d;
    logic          err_key_q, err_key_d;
    logic          out_valid_q, out_valid_d;
    logic [KW-1:0] out_key_q, out_key_d;
    logic [VW-1:0] out_value_q, out_value_d;
    logic [KW-1:0] now_w;
    logic          slot_free;
    logic          due;
    logic          want_push;
    logic          push;
    logic          pop;

    pq_tick_ctr #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick_en (tick_en),
        .now     (now_w)
    );

    assign slot_free = !out_valid_q || out_ready;
    assign due       = !pi.empty && (pi.odata.key <= now_w) && slot_free;
    assign want_push = in_valid && !pi.full;

    // Scheduler FSM: choose one PQ op per visit to S_IDLE, drain the queue on flush.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        flush_ph_d = flush_ph_q;
        err_key_d  = err_key_q;
        in_ready   = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_pend_q) begin
                    state_d    = S_FLUSH;
                    flush_ph_d = 1'b0;
                end else if (due && want_push) begin
                    state_d = rr_q ? S_PUSH : S_POP;
                    rr_d    = !rr_q;
                end else if (due) begin
                    state_d = S_POP;
                end else if (want_push) begin
                    state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                in_ready = in_valid && !pi.full;
                if (in_ready) begin
                    if (in_key == KEYINF) begin
                        err_key_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                state_d = S_SETTLE;
            end
            S_POP: begin
                pop     = 1'b1;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (!flush_ph_q) begin
                    if (pi.empty) begin
                        state_d = S_IDLE;
                    end else begin
                        pop        = 1'b1;
                        flush_ph_d = 1'b1;
                    end
                end else begin
                    flush_ph_d = 1'b0;
                    if (pi.empty) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flush request latch: captured in any state except while already flushing.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (flush && (state_q != S_FLUSH)) begin
            flush_pend_d = 1'b1;
        end
        if ((state_q == S_IDLE) && flush_pend_q) begin
            flush_pend_d = 1'b0;
        end
    end

    // Output slot: loads the head on a scheduled pop, otherwise clears on handshake.
    always_comb begin
        out_valid_d = out_valid_q;
        out_key_d   = out_key_q;
        out_value_d = out_value_q;
        if (state_q == S_POP) begin
            out_valid_d = 1'b1;
            out_key_d   = pi.odata.key;
            out_value_d = pi.odata.value;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State, arbitration and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rr_q         <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_ph_q   <= 1'b0;
            err_key_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_key_q    <= '0;
            out_value_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            flush_pend_q <= flush_pend_d;
            flush_ph_q   <= flush_ph_d;
            err_key_q    <= err_key_d;
            out_valid_q  <= out_valid_d;
            out_key_q    <= out_key_d;
            out_value_q  <= out_value_d;
        end
    end

    assign pi.push   = push;
    assign pi.pop    = pop;
    assign pi.idata  = {in_key, in_value};
    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;
    assign out_value = out_value_q;
    assign now       = now_w;
    assign busy      = (state_q == S_FLUSH);
    assign err_key   = err_key_q;

endmodule
